rr_sel_arbiter: RTL and testbench
=================================

# rr_sel_arbiter

Round-robin arbiter that sits directly upstream of the 2x4 active-low-enable decoder and drives its 2-bit select and enable. Four requesters compete for one decoded output line. The block grants one requester at a time, holds the select stable for the whole grant, and releases on a done handshake. It inserts a one-cycle dead gap between grants so the decoder outputs never glitch from one line to another.

## Interface
Parameters:
- `TIMEOUT_CYC`, 16: maximum grant length in cycles (used only when the watchdog is compiled in); legal range 2..255.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req`, in, 4: request lines; `req[i]` held high by requester i until served.
- `done`, in, 1: pulse from the granted requester ending its grant.
- `sel`, out, 2: index of the granted requester; drives decoder `in`.
- `en_n`, out, 1: active-low decoder enable; 0 only during GRANT.
- `gnt_valid`, out, 1: high during GRANT (positive copy of `~en_n`).
- `timeout`, out, 1: one-cycle pulse when the watchdog aborts a grant; constant 0 without the macro.

## Operation
- All outputs are registered. Reset values: `sel`=2'b00, `en_n`=1, `gnt_valid`=0, `timeout`=0, internal `last`=2'd3, state IDLE, watchdog count 0.
- The FSM has three states: IDLE, GRANT and GAP.
- IDLE: if `req`≠0, pick the winner by searching upward from `last+1` (mod 4). Load `sel` with the winner, set `en_n`=0 and `gnt_valid`=1, and go to GRANT. If `req`=0, stay in IDLE with outputs unchanged except `en_n`=1.
- GRANT: `sel` is frozen. Exit to GAP on any of:
  - `done`=1;
  - `req[sel]`=0 (requester abandoned);
  - watchdog expiry.
- On exit from GRANT: `last`←`sel`, `en_n`=1, `gnt_valid`=0.
- GAP: exactly one cycle, then IDLE. `req` is ignored and `sel` holds its last value.
- `done` is ignored outside GRANT. `done` together with `req[sel]` dropping counts as a single release.
- Fairness: a requester that has just been served has the lowest priority in the next arbitration. With all four requesting, the grant order is 0,1,2,3,0…
- `sel` never changes while `en_n`=0.

## Timing
- Grant latency: with `req` first high at edge k (state IDLE), `en_n`=0 and `sel` are valid after edge k.
- Release latency: with `done` high at edge m (in GRANT), `en_n`=1 after edge m.
- Minimum grant length is 1 cycle. GAP then lasts 1 cycle, so the earliest next grant is after edge m+2. Steady-state throughput is one grant per 3 cycles.
- Watchdog: the counter clears on entry to GRANT and increments each GRANT cycle. When the count is `TIMEOUT_CYC-1` at an edge, the block forces exit, and `timeout`=1 for the following cycle only. If `done` arrives at that same edge, it is a normal release and `timeout` stays 0.
- Asynchronous reset mid-grant: `en_n` goes to 1 immediately, with no wait for a clock. After reset deassertion, arbitration restarts from requester 0.

## Configuration
- `RR_SEL_TIMEOUT_EN` defined: the watchdog counter (8-bit) and the `timeout` pulse are present, and `TIMEOUT_CYC` applies.
- Not defined: no counter; a grant lasts until `done` or the request drops, and `timeout` is tied to 0. `TIMEOUT_CYC` is unused.

## Structure
- Shared package holds:
  - state encoding constants: IDLE=2'b00, GRANT=2'b01, GAP=2'b10;
  - `NREQ`=4;
  - `SEL_W`=2.
- One combinational sub-module, `rr_pick`. Inputs: `req[3:0]`, `last[1:0]`. Outputs: `win[1:0]`, `any`. It implements the rotated priority search. The top level holds the FSM, registers and watchdog.

## Test plan
- Reset, then `req`=4'b0100 → after 1 edge `sel`=2, `en_n`=0. A `done` pulse releases the grant, `en_n`=1 after the next edge, and the block returns to IDLE 1 cycle later.
- `req`=4'b1111 held, `done` pulsed in every grant → grant sequence `sel`=0,1,2,3,0 with a one-cycle `en_n`=1 gap between each.
- `req`=4'b0011 held with `last`=0 → grant goes to 1 before 0. Verify no starvation over 8 grants.
- Grant requester 3, then drop `req[3]` without `done` → release on that edge, `timeout`=0, `last`=3.
- With `RR_SEL_TIMEOUT_EN` and `TIMEOUT_CYC`=4, never assert `done` → `en_n` low for exactly 4 cycles, then a single `timeout` pulse. Without the macro, `en_n` stays low indefinitely.
- Assert `rst` asynchronously mid-GRANT → `en_n`=1, `sel`=0 and `gnt_valid`=0 without a clock edge. The first grant after reset goes to the lowest active index.

Source files
------------

// File: rtl/rr_sel_arbiter_pkg.sv
// Shared definitions for the round-robin decoder-select arbiter:
// FSM state encoding and requester/select widths.
package rr_sel_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// rr_pick: combinational rotated-priority search. The winner is the first
// active request found searching upward from last+1 (mod NREQ), so the most
// recently served requester is always checked last.
module rr_pick
  import rr_sel_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Walk the request vector starting one past the last winner; first hit wins.
  always_comb begin
    win   = '0;
    any   = |req;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: four-way round-robin arbiter driving the 2-bit select and
// active-low enable of a downstream 2x4 decoder. A grant holds sel frozen
// until done, request drop, or (optionally) watchdog expiry, and is always
// followed by a one-cycle dead gap so decoder outputs never glitch.
// Optional feature: define RR_SEL_TIMEOUT_EN to build in the grant watchdog
// (8-bit counter, TIMEOUT_CYC cycles max) and its timeout pulse.
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic             en_n,
  output logic             gnt_valid,
  output logic             timeout
);

  // Reject out-of-range watchdog lengths at elaboration time.
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
    $error("rr_sel_arbiter: TIMEOUT_CYC must be within 2..255");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             en_n_q, en_n_d;
  logic             gnt_q, gnt_d;
  logic             timeout_q, timeout_d;

  logic [SEL_W-1:0] pick_win;
  logic             pick_any;
  logic             wd_expire;
  logic             release_grant;

  rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .win  (pick_win),
    .any  (pick_any)
  );

`ifdef RR_SEL_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wd_cnt_q, wd_cnt_d;

  assign wd_expire = (state_q == GRANT) && (wd_cnt_q == WD_LAST);

  // Counter sits at zero outside GRANT, so it is clear on grant entry.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == GRANT) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end
  end

  // Watchdog count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Any of done, abandoned request or watchdog ends the current grant.
  assign release_grant = done || !req[sel_q] || wd_expire;

  // Next-state and registered-output logic for IDLE / GRANT / GAP.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    en_n_d    = en_n_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_win;
          en_n_d  = 1'b0;
          gnt_d   = 1'b1;
          state_d = GRANT;
        end else begin
          en_n_d  = 1'b1;
        end
      end
      GRANT: begin
        if (release_grant) begin
          last_d    = sel_q;
          en_n_d    = 1'b1;
          gnt_d     = 1'b0;
          // A normal release on the expiry edge takes precedence.
          timeout_d = wd_expire && !done && req[sel_q];
          state_d   = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        en_n_d  = 1'b1;
        gnt_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the decoder disabled at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= SEL_W'(NREQ - 1);
      en_n_q    <= 1'b1;
      gnt_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      en_n_q    <= en_n_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel       = sel_q;
  assign en_n      = en_n_q;
  assign gnt_valid = gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter: reset values, round-robin order,
// fairness between two requesters, abandon release, watchdog (or its
// absence when RR_SEL_TIMEOUT_EN is undefined) and asynchronous reset.
module tb_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       en_n;
  logic       gnt_valid;
  logic       timeout;

  int n_total = 0;
  int n_bad   = 0;

  rr_sel_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .en_n      (en_n),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got=expired exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int exp_rr[5];
    int cnt0;
    int cnt1;
    exp_rr = '{0, 1, 2, 3, 0};
    cnt0 = 0;
    cnt1 = 0;

    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_en_n", en_n, 1);
    chk("rst_gnt", gnt_valid, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    step();
    chk("idle_en_n", en_n, 1);

    // All four requesting: order 0,1,2,3,0 with a gap between grants.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_sel", sel, exp_rr[i]);
      chk("rr_en_n", en_n, 0);
      chk("rr_gnt", gnt_valid, 1);
      done = 1'b1;
      step();
      chk("rr_rel_en_n", en_n, 1);
      chk("rr_rel_sel_hold", sel, exp_rr[i]);
      done = 1'b0;
      step();
      chk("rr_gap_en_n", en_n, 1);
    end
    req = 4'b0000;

    // Single request 2, done release, back to idle.
    req = 4'b0100;
    step();
    chk("one_sel", sel, 2);
    chk("one_en_n", en_n, 0);
    done = 1'b1;
    step();
    chk("one_rel_en_n", en_n, 1);
    chk("one_rel_gnt", gnt_valid, 0);
    done = 1'b0;
    req  = 4'b0000;
    step();
    chk("one_gap_en_n", en_n, 1);
    step();
    chk("one_idle_en_n", en_n, 1);

    // Serve requester 0 so last=0.
    req = 4'b0001;
    step();
    chk("l0_sel", sel, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    step();

    // Two requesters with last=0: 1 first, then strict alternation.
    req = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("pair_sel", sel, (i % 2 == 0) ? 1 : 0);
      if (sel == 2'd0) cnt0++;
      if (sel == 2'd1) cnt1++;
      done = 1'b1;
      step();
      done = 1'b0;
      step();
    end
    chk("pair_cnt0", cnt0, 4);
    chk("pair_cnt1", cnt1, 4);
    req = 4'b0000;

    // Grant 3, then abandon without done.
    req = 4'b1000;
    step();
    chk("drop_sel", sel, 3);
    chk("drop_en_n", en_n, 0);
    step();
    chk("drop_hold_en_n", en_n, 0);
    req = 4'b0000;
    step();
    chk("drop_rel_en_n", en_n, 1);
    chk("drop_rel_gnt", gnt_valid, 0);
    chk("drop_timeout", timeout, 0);
    step();
    req = 4'b1111;
    step();
    chk("drop_last3_next", sel, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    step();

    // Grant held with no done.
    req = 4'b0010;
    step();
    chk("wd_sel", sel, 1);
    chk("wd_en_n", en_n, 0);
`ifdef RR_SEL_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wd_hold_en_n", en_n, 0);
      chk("wd_hold_timeout", timeout, 0);
    end
    step();
    chk("wd_exp_en_n", en_n, 1);
    chk("wd_exp_timeout", timeout, 1);
    req = 4'b0000;
    step();
    chk("wd_pulse_end", timeout, 0);
`else
    for (int i = 0; i < 10; i++) begin
      step();
      chk("nowd_hold_en_n", en_n, 0);
      chk("nowd_timeout", timeout, 0);
    end
    done = 1'b1;
    step();
    chk("nowd_rel_en_n", en_n, 1);
    done = 1'b0;
    req  = 4'b0000;
    step();
`endif
    step();

    // Asynchronous reset in the middle of a grant.
    req = 4'b1101;
    step();
    chk("ar_pre_sel", sel, 2);
    chk("ar_pre_en_n", en_n, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_en_n", en_n, 1);
    chk("ar_sel", sel, 0);
    chk("ar_gnt", gnt_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("ar_first_sel", sel, 0);
    chk("ar_first_en_n", en_n, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
